// File: rtl/rhsd_seq_pkg.sv
// rhsd_seq_pkg: shared state encoding and width helper for the ripple half-subtractor decrementer.
package rhsd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(v)), never less than 1 so a single-chunk build still has an index bit
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rhsd_seq_rhsc.sv
// rhsc: combinational K-bit ripple half-subtractor chunk (D = A - B_IN, B_OUT = chunk underflow).
module rhsc #(
    parameter int K = 2
) (
    input  logic [K-1:0] A,
    input  logic         B_IN,
    output logic [K-1:0] D,
    output logic         B_OUT
);

    logic [K:0] w_b;

    assign w_b[0] = B_IN;

    for (genvar i = 0; i < K; i++) begin : g_bit
        assign D[i]       = A[i] ^ w_b[i];
        assign w_b[i + 1] = ~A[i] & w_b[i];
    end

    assign B_OUT = w_b[K];

endmodule

// File: rtl/rhsd_seq.sv
// rhsd_seq: sequential decrementer, DIFF = A - B_IN processed K bits per cycle behind valid/ready.
// Define RHSD_SATURATE_EN to clamp an underflowing result to zero instead of wrapping.
module rhsd_seq
    import rhsd_seq_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [N-1:0] A,
    input  logic         B_IN,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [N-1:0] DIFF,
    output logic         BORROW_OUT
);

    localparam int M  = N / K;
    localparam int IW = clog2_min1(M);

    if (N % K != 0) begin : g_bad_width
        $error("rhsd_seq: N must be a multiple of K");
    end

    state_t          r_state;
    logic [N-1:0]    r_work;
    logic [IW-1:0]   r_idx;
    logic            r_b;
    logic [K-1:0]    w_a;
    logic [K-1:0]    w_d;
    logic            w_bo;
    logic [N-1:0]    w_next;
    logic [N-1:0]    w_res;
    logic            w_last;

    assign w_a    = r_work[r_idx * K +: K];
    assign w_last = (r_idx == IW'(M - 1));

    rhsc #(.K(K)) u_rhsc (
        .A     (w_a),
        .B_IN  (r_b),
        .D     (w_d),
        .B_OUT (w_bo)
    );

    always_comb begin
        w_next                  = r_work;
        w_next[r_idx * K +: K]  = w_d;
    end

`ifdef RHSD_SATURATE_EN
    assign w_res = w_bo ? '0 : w_next;
`else
    assign w_res = w_next;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_idx      <= '0;
            r_b        <= 1'b0;
            IN_READY   <= 1'b1;
            OUT_VALID  <= 1'b0;
            DIFF       <= '0;
            BORROW_OUT <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (IN_VALID) begin
                    r_work   <= A;
                    r_b      <= B_IN;
                    r_idx    <= '0;
                    IN_READY <= 1'b0;
                    r_state  <= RUN;
                end
                RUN: begin
                    r_work <= w_next;
                    r_b    <= w_bo;
                    r_idx  <= r_idx + IW'(1);
                    if (w_last) begin
                        DIFF       <= w_res;
                        BORROW_OUT <= w_bo;
                        OUT_VALID  <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: if (OUT_READY) begin
                    OUT_VALID <= 1'b0;
                    IN_READY  <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rhsd_seq.sv
// tb_rhsd_seq: directed and swept checks of rhsd_seq (N=8, K=2) against hand/reference expectations.
module tb_rhsd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic       b_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       borrow_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rhsd_seq #(.N(8), .K(2)) dut (
        .CLK        (clk),
        .RST        (rst),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .A          (a),
        .B_IN       (b_in),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .DIFF       (diff),
        .BORROW_OUT (borrow_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full operation: accept, measure latency, check result, stall, then drain.
    task automatic op(input logic [7:0] av, input logic bv, input int stall,
                      input logic [7:0] exp_d, input logic exp_b);
        int lat;
        out_ready = 1'b0;
        check("in_ready_idle", in_ready, 1);
        a = av;
        b_in = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = ~av;
        b_in = ~bv;
        check("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", lat, 4);
        check("diff", diff, exp_d);
        check("borrow", borrow_out, exp_b);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            a = 8'hA5;
            step();
            check("stall_valid", out_valid, 1);
            check("stall_diff", diff, exp_d);
            check("stall_borrow", borrow_out, exp_b);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
    endtask

    function automatic logic [7:0] ref_diff(input logic [7:0] av, input logic bv);
`ifdef RHSD_SATURATE_EN
        return (av == 8'h00 && bv) ? 8'h00 : av - {7'd0, bv};
`else
        return av - {7'd0, bv};
`endif
    endfunction

    initial begin
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        rst = 1'b0;

        op(8'h05, 1'b1, 0, 8'h04, 1'b0);
`ifdef RHSD_SATURATE_EN
        op(8'h00, 1'b1, 0, 8'h00, 1'b1);
`else
        op(8'h00, 1'b1, 0, 8'hFF, 1'b1);
`endif
        op(8'h80, 1'b1, 0, 8'h7F, 1'b0);
        op(8'h80, 1'b0, 0, 8'h80, 1'b0);
        op(8'h10, 1'b1, 5, 8'h0F, 1'b0);

        // Reset during the second RUN cycle discards the operation.
        a = 8'h33;
        b_in = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_borrow", borrow_out, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_quiet", out_valid, 0);
        end
        op(8'h01, 1'b1, 0, 8'h00, 1'b0);

        for (int av = 0; av < 256; av++) begin
            for (int bv = 0; bv < 2; bv++) begin
                op(8'(av), 1'(bv), int'($urandom_range(0, 3)),
                   ref_diff(8'(av), 1'(bv)), (av == 0 && bv == 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rhsd_seq.md
Name: rhsd_seq

Overview:
- Sequential ripple half-subtractor decrementer. It is the inverse-direction companion of the combinational ripple half-adder incrementer.
- Computes DIFF = A - B_IN, where B_IN is a 1-bit borrow-in. Works K bits per cycle; the borrow ripples across cycles.
- Sits behind a valid/ready handshake. Used where a full N-bit combinational borrow chain would break timing.

Parameters:
- N, 8, operand width in bits. Must be a multiple of K.
- K, 2, bits processed per cycle. N/K is the iteration count.

Ports:
- CLK  input  1  clock; rising edge
- RST  input  1  synchronous, active-high reset
- IN_VALID  input  1  operand available
- IN_READY  output  1  block can accept an operand
- A  input  N  minuend
- B_IN  input  1  borrow-in (subtract 1 when high)
- OUT_VALID  output  1  result available
- OUT_READY  input  1  consumer accepts result
- DIFF  output  N  A - B_IN, modulo 2^N
- BORROW_OUT  output  1  underflow flag: A==0 and B_IN==1

Behaviour:
- Interface (already decided): one clock, CLK; reset RST is synchronous and active-high.
- Reset values: state=IDLE, IN_READY=1, OUT_VALID=0, DIFF=0, BORROW_OUT=0, chunk index=0, internal borrow=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: IN_READY=1. On IN_VALID&IN_READY: capture A into a working register, load borrow<=B_IN, idx<=0, go to RUN.
  - RUN: IN_READY=0. Each edge handles chunk idx (bits idx*K+K-1 : idx*K):
    - per bit: d = a ^ b; b_next = ~a & b.
    - write the chunk's d bits back into the working register; borrow<=chunk borrow-out; idx<=idx+1.
    - after the chunk with idx = N/K-1: go to DONE, DIFF<=working result, BORROW_OUT<=final borrow.
  - DONE: OUT_VALID=1. DIFF and BORROW_OUT are held stable while OUT_READY=0. On OUT_READY: OUT_VALID<=0, go to IDLE.
- Latency: OUT_VALID rises exactly N/K edges after the acceptance edge. There is no early exit when the borrow dies.
- Throughput: at most one operation per N/K+2 cycles. IN_READY is high only in IDLE; there is no accept from DONE.
- B_IN=0 still takes the full N/K cycles; DIFF=A.
- Wrap: A=0, B_IN=1 gives DIFF=all ones, BORROW_OUT=1.
- IN_VALID while not IDLE: ignored. The operand is not captured.
- RST has priority over every transition, including mid-RUN and in DONE. All state returns to reset values on the next edge and the result is discarded.
- OUT_VALID and IN_READY are registered, not combinational from inputs.
- Width rule: idx width is clog2(N/K), minimum 1. N%K!=0 is illegal and must be flagged by an elaboration-time check.

Optional Feature:
- Macro: RHSD_SATURATE_EN.
- Defined: on underflow (A==0, B_IN==1), DIFF=0 instead of all ones. BORROW_OUT is still 1. All other results are unchanged.
- Undefined: modulo-2^N wrap as described above.
- Latency is identical either way; the clamp is applied at the RUN->DONE load.

Decomposition:
- Shared header rhsd_defs.vh:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - a function or macro for clog2.
- One sub-module: rhsc, a combinational K-bit ripple half-subtractor chunk.
  - ports: [K-1:0] A, B_IN, [K-1:0] D, B_OUT.
  - instantiated once; its inputs are muxed by idx.

Test Plan (N=8, K=2):
- A=0x05, B_IN=1, OUT_READY=1 -> OUT_VALID exactly 4 cycles after accept; DIFF=0x04, BORROW_OUT=0.
- A=0x00, B_IN=1 -> DIFF=0xFF, BORROW_OUT=1. With RHSD_SATURATE_EN: DIFF=0x00, BORROW_OUT=1.
- A=0x80, B_IN=1 -> DIFF=0x7F, borrow crosses all 4 chunks. Then A=0x80, B_IN=0 -> DIFF=0x80.
- Backpressure: A=0x10, B_IN=1 with OUT_READY=0 for 5 cycles -> OUT_VALID held; DIFF=0x0F stable. IN_VALID pulses are ignored and IN_READY stays 0. OUT_READY=1 -> IDLE next edge.
- RST asserted on the 2nd RUN cycle (A=0x33) -> next edge: IDLE, IN_READY=1, OUT_VALID=0, DIFF=0. A following A=0x01, B_IN=1 -> DIFF=0x00.
- Exhaustive sweep: all 256 A values × B_IN∈{0,1}, random OUT_READY stalls -> DIFF equals a reference model, and latency is always 4.
